// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax numerator path: BF16 constants, field
// widths, the row FSM states and the BF16 helper functions.
package softmax_pkg;

  localparam logic [15:0] BF16_ZERO    = 16'h0000;
  localparam logic [15:0] BF16_POS_MAX = 16'h7F7F;
  localparam logic [15:0] BF16_NEG_MAX = 16'hFF7F;
  localparam logic [15:0] BF16_ONE     = 16'h3F80;

  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam int BIAS  = 127;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Sign-magnitude a > b; assumes -0 has already been folded to +0.
  function automatic logic bf16_gt(input logic [15:0] a, input logic [15:0] b);
    logic r;
    if (a[15] != b[15]) begin
      r = b[15];
    end else if (a[15] == 1'b0) begin
      r = (a[14:0] > b[14:0]);
    end else begin
      r = (a[14:0] < b[14:0]);
    end
    return r;
  endfunction

  function automatic logic [15:0] bf16_sanitize(input logic [15:0] x);
    logic [15:0] r;
    if (x[14:7] == 8'h00) begin
      r = BF16_ZERO;
    end else if (x[14:7] == 8'hFF) begin
      r = x[15] ? BF16_NEG_MAX : BF16_POS_MAX;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/bf16_sub.sv
// Combinational BF16 y = a - b on sanitised operands: round-to-nearest-even,
// flush of subnormal results to +0, saturation to signed max-finite.
module bf16_sub
  import softmax_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic             b_sign_s, eff_sub_s, res_sign_s, sticky_s, rnd_up_s;
  logic [EXP_W-1:0] el_s, es_s, sh_s;
  logic [10:0]      l_ext_s, s_ext_s, s_sh_s, mask_s, n_s;
  logic [11:0]      r_s;
  logic [3:0]       lz_s;
  logic [7:0]       m_rnd_s;
  logic signed [9:0] e_norm_s, e_fin_s;

  function automatic logic [3:0] clz11(input logic [10:0] v);
    logic [3:0] n;
    n = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (v[i]) n = 4'(10 - i);
    end
    return n;
  endfunction

  // Align the smaller magnitude with guard/round/sticky, add or subtract, normalise, round.
  always_comb begin
    b_sign_s = ~b[15];
    eff_sub_s = a[15] ^ b_sign_s;
    mask_s = 11'd0;
    if (a[14:0] >= b[14:0]) begin
      el_s = a[14:7];
      es_s = b[14:7];
      l_ext_s = {|a[14:7], a[6:0], 3'b000};
      s_ext_s = {|b[14:7], b[6:0], 3'b000};
      res_sign_s = a[15];
    end else begin
      el_s = b[14:7];
      es_s = a[14:7];
      l_ext_s = {|b[14:7], b[6:0], 3'b000};
      s_ext_s = {|a[14:7], a[6:0], 3'b000};
      res_sign_s = b_sign_s;
    end
    sh_s = el_s - es_s;
    if (sh_s > 8'd10) begin
      s_sh_s = 11'd0;
      sticky_s = |s_ext_s;
    end else begin
      mask_s = (11'd1 << sh_s[3:0]) - 11'd1;
      s_sh_s = s_ext_s >> sh_s[3:0];
      sticky_s = |(s_ext_s & mask_s);
    end
    s_sh_s = s_sh_s | {10'd0, sticky_s};
    if (eff_sub_s) begin
      r_s = {1'b0, l_ext_s} - {1'b0, s_sh_s};
    end else begin
      r_s = {1'b0, l_ext_s} + {1'b0, s_sh_s};
    end
    lz_s = clz11(r_s[10:0]);
    if (r_s[11]) begin
      n_s = {r_s[11:2], r_s[1] | r_s[0]};
      e_norm_s = signed'({2'b00, el_s}) + 10'sd1;
    end else begin
      n_s = r_s[10:0] << lz_s;
      e_norm_s = signed'({2'b00, el_s}) - signed'({6'd0, lz_s});
    end
    rnd_up_s = n_s[2] & (n_s[3] | n_s[1] | n_s[0]);
    // A mantissa carry clears the fraction and bumps the exponent.
    m_rnd_s = {1'b0, n_s[9:3]} + {7'd0, rnd_up_s};
    e_fin_s = e_norm_s + signed'({9'd0, m_rnd_s[7]});
    if (n_s[10] == 1'b0) begin
      y = BF16_ZERO;
    end else if (e_fin_s < 10'sd1) begin
      y = BF16_ZERO;
    end else if (e_fin_s > 10'sd254) begin
      y = {res_sign_s, BF16_POS_MAX[14:0]};
    end else begin
      y = {res_sign_s, e_fin_s[7:0], m_rnd_s[6:0]};
    end
  end

endmodule

// File: rtl/softmax_max_sub.sv
// Buffers one row of BF16 logits while tracking its maximum, then streams
// x[i] - max through a two-stage (RAM read, result register) drain pipeline.
module softmax_max_sub
  import softmax_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic [15:0] row_max,
  output logic        err_overflow
);

  state_e          state_r;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r, last_idx_r;
  logic            rd_done_r, rd_valid_r, rd_last_r;
  logic [15:0]     rd_data_r, max_r, out_data_r;
  logic            in_ready_r, out_valid_r, out_last_r, err_ovf_r;
  logic [15:0]     mem_r [DEPTH];
  logic [15:0]     san_s, sub_s;
  logic            in_hs_s, at_cap_s, row_end_s, adv_s, rd_issue_s, out_done_s;

  // Handshake decode and drain pipeline advance conditions.
  always_comb begin
    san_s      = bf16_sanitize(in_data);
    in_hs_s    = in_valid & in_ready_r;
    at_cap_s   = (wr_ptr_r == AW'(DEPTH - 1));
    row_end_s  = in_hs_s & (in_last | at_cap_s);
    adv_s      = ~out_valid_r | out_ready;
    rd_issue_s = (state_r == DRAIN) & ~rd_done_r & (~rd_valid_r | adv_s);
    out_done_s = out_valid_r & out_ready & out_last_r;
  end

  // Row buffer: write on input handshake, synchronous read when the pipeline has room.
  always_ff @(posedge clk) begin
    if (in_hs_s) mem_r[wr_ptr_r] <= san_s;
    if (rd_issue_s) rd_data_r <= mem_r[rd_ptr_r];
  end

  bf16_sub u_sub (
    .a (rd_data_r),
    .b (max_r),
    .y (sub_s)
  );

  // Fill/drain control, running max and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= FILL;
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      last_idx_r  <= {AW{1'b0}};
      rd_done_r   <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_last_r   <= 1'b0;
      max_r       <= BF16_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= BF16_ZERO;
      out_last_r  <= 1'b0;
      err_ovf_r   <= 1'b0;
    end else begin
      // Truncation is the only way a row can end without in_last.
      err_ovf_r <= row_end_s & ~in_last;
      case (state_r)
        FILL: begin
          if (in_hs_s) begin
            if ((wr_ptr_r == {AW{1'b0}}) || bf16_gt(san_s, max_r)) max_r <= san_s;
            if (row_end_s) begin
              state_r    <= DRAIN;
              in_ready_r <= 1'b0;
              last_idx_r <= wr_ptr_r;
              wr_ptr_r   <= {AW{1'b0}};
            end else begin
              wr_ptr_r <= wr_ptr_r + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (rd_issue_s) begin
            rd_ptr_r   <= rd_ptr_r + AW'(1);
            rd_last_r  <= (rd_ptr_r == last_idx_r);
            rd_done_r  <= (rd_ptr_r == last_idx_r);
            rd_valid_r <= 1'b1;
          end else if (adv_s) begin
            rd_valid_r <= 1'b0;
          end
          if (adv_s) begin
            out_valid_r <= rd_valid_r;
            out_data_r  <= sub_s;
            out_last_r  <= rd_last_r;
          end
          if (out_done_s) begin
            state_r    <= FILL;
            in_ready_r <= 1'b1;
            rd_ptr_r   <= {AW{1'b0}};
            rd_done_r  <= 1'b0;
          end
        end
        default: state_r <= FILL;
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_data     = out_data_r;
  assign out_last     = out_last_r;
  assign row_max      = max_r;
  assign err_overflow = err_ovf_r;

endmodule

// File: tb/tb_softmax_max_sub.sv
// Directed bench for softmax_max_sub: expected beats are queued when a row is
// driven and compared as the DUT hands them out; DEPTH is shrunk to 4.
module tb_softmax_max_sub;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last, err_overflow;
  logic [15:0] in_data, out_data, row_max;

  beat_t       sb[$];
  int          tests = 0, fails = 0, cyc = 0, pops = 0, first_pop = 0, last_pop = 0, ovf_seen = 0;
  bit          rnd_ready = 1'b0, hold_pending = 1'b0;
  logic [15:0] held_d;
  logic        held_l;

  softmax_max_sub #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .row_max      (row_max),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: pick out_ready for the coming edge, then score what that edge will transfer.
  task automatic step();
    beat_t e;
    @(negedge clk);
    cyc++;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (err_overflow === 1'b1) ovf_seen++;
    if (hold_pending) begin
      chk("hold_valid", 16'(out_valid), 16'd1);
      chk("hold_data", out_data, held_d);
      chk("hold_last", 16'(out_last), 16'(held_l));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      hold_pending = 1'b0;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL extra_beat: observed %h expected no beat", out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last", 16'(out_last), 16'(e.l));
        if (pops == 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
    end else if (out_valid === 1'b1) begin
      hold_pending = 1'b1;
      held_d = out_data;
      held_l = out_last;
    end else begin
      hold_pending = 1'b0;
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic l);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    chk("accept", 16'(in_ready), 16'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) step();
    chk("drain_left", 16'(sb.size()), 16'd0);
  endtask

  task automatic expect_beat(input logic [15:0] d, input logic l);
    beat_t e;
    e.d = d;
    e.l = l;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_last", 16'(out_last), 16'd0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_row_max", row_max, 16'h0000);
    chk("rst_ovf", 16'(err_overflow), 16'd0);
    rst = 1'b0;

    // 1, 2, 3: latency, ordering and back-to-back beats.
    pops = 0;
    expect_beat(16'hC000, 1'b0); expect_beat(16'hBF80, 1'b0); expect_beat(16'h0000, 1'b1);
    drive(16'h3F80, 1'b0); drive(16'h4000, 1'b0); drive(16'h4040, 1'b1);
    chk("lat0_valid", 16'(out_valid), 16'd0);
    chk("drain_in_ready", 16'(in_ready), 16'd0);
    step();
    chk("lat1_valid", 16'(out_valid), 16'd0);
    step();
    chk("lat2_valid", 16'(out_valid), 16'd1);
    wait_drain();
    chk("row_max_pos", row_max, 16'h4040);
    chk("b2b_span", 16'(last_pop - first_pop), 16'd2);

    // -3, -1
    expect_beat(16'hC000, 1'b0); expect_beat(16'h0000, 1'b1);
    drive(16'hC040, 1'b0); drive(16'hBF80, 1'b1);
    wait_drain();
    chk("row_max_neg", row_max, 16'hBF80);

    // 0.5 - 256 rounds to even.
    expect_beat(16'hC380, 1'b0); expect_beat(16'h0000, 1'b1);
    drive(16'h3F00, 1'b0); drive(16'h4380, 1'b1);
    wait_drain();
    chk("row_max_tie", row_max, 16'h4380);

    // Denormal and Inf sanitising.
    expect_beat(16'hFF7F, 1'b0); expect_beat(16'h0000, 1'b0); expect_beat(16'hFF7F, 1'b1);
    drive(16'h0001, 1'b0); drive(16'h7F80, 1'b0); drive(16'h3F80, 1'b1);
    wait_drain();
    chk("row_max_spec", row_max, 16'h7F7F);

    // Mixed-sign magnitude overflow saturates.
    expect_beat(16'h0000, 1'b0); expect_beat(16'hFF7F, 1'b1);
    drive(16'h7F7F, 1'b0); drive(16'hFF7F, 1'b1);
    wait_drain();
    chk("row_max_sat", row_max, 16'h7F7F);

    // Truncation at DEPTH with random backpressure; the extra beats start the next row.
    rnd_ready = 1'b1;
    ovf_seen = 0;
    expect_beat(16'hC040, 1'b0); expect_beat(16'hC000, 1'b0);
    expect_beat(16'hBF80, 1'b0); expect_beat(16'h0000, 1'b1);
    expect_beat(16'hBF80, 1'b0); expect_beat(16'hC000, 1'b0); expect_beat(16'h0000, 1'b1);
    drive(16'h3F80, 1'b0); drive(16'h4000, 1'b0); drive(16'h4040, 1'b0); drive(16'h4080, 1'b0);
    chk("ovf_pulse", 16'(err_overflow), 16'd1);
    chk("ovf_in_ready", 16'(in_ready), 16'd0);
    chk("ovf_row_max", row_max, 16'h4080);
    drive(16'h4000, 1'b0); drive(16'h3F80, 1'b0); drive(16'h4040, 1'b1);
    chk("row2_max", row_max, 16'h4040);
    chk("ovf_pulses", 16'(ovf_seen), 16'd1);
    for (int k = 0; k < 200 && sb.size() > 2; k++) step();
    chk("mid_drain_left", 16'(sb.size()), 16'd2);

    // Reset in the middle of the drain discards the row.
    rst = 1'b1;
    sb.delete();
    hold_pending = 1'b0;
    step();
    chk("mrst_out_valid", 16'(out_valid), 16'd0);
    chk("mrst_in_ready", 16'(in_ready), 16'd1);
    chk("mrst_row_max", row_max, 16'h0000);
    rst = 1'b0;

    // Recovery with a single-element row.
    expect_beat(16'h0000, 1'b1);
    drive(16'h3F80, 1'b1);
    wait_drain();
    chk("row_max_single", row_max, 16'h3F80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
